// File: rtl/lin2log_if.sv
// lin2log handshake bundle: sample in, attenuation out.
// Feature macro used by the converter: LIN2LOG_ROUND_EN.
interface lin2log_if #(
   parameter int ISZ = 16,
   parameter int FSZ = 8
);
   localparam int OSZ = 5 + FSZ;

   logic           in_valid;
   logic           in_ready;
   logic [ISZ-1:0] lin;
   logic           out_valid;
   logic           out_ready;
   logic [OSZ-1:0] atten;
   logic           zero;

   modport master (
      output in_valid, lin, out_ready,
      input  in_ready, out_valid, atten, zero
   );

   modport slave (
      input  in_valid, lin, out_ready,
      output in_ready, out_valid, atten, zero
   );
endinterface

// File: rtl/lin2log.sv
// Iterative linear-to-log converter (normalise, then square for fraction bits).
// LIN2LOG_ROUND_EN adds one fraction bit and rounds half-up.
module lin2log #(
   parameter int ISZ = 16,
   parameter int FSZ = 8
) (
   input  logic     clk,
   input  logic     reset,
   lin2log_if.slave bus
);
   localparam int OSZ = 5 + FSZ;
`ifdef LIN2LOG_ROUND_EN
   localparam int FW = FSZ + 1;
`else
   localparam int FW = FSZ;
`endif
   localparam int IW = $clog2(FW + 1);

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      FRAC,
      DONE
   } state_t;

   state_t           state, state_n;
   logic [ISZ-1:0]   m, m_n;
   logic [4:0]       cnt, cnt_n;
   logic [4:0]       cnt_p1;
   logic [FW-1:0]    f, f_n;
   logic [FW-1:0]    f_sh;
   logic [IW-1:0]    idx, idx_n;
   logic [OSZ-1:0]   atten, atten_n;
   logic             zero, zero_n;
   logic [2*ISZ-1:0] sq;
   logic             sq_ge2;
   logic [FSZ:0]     f_fin;
   logic [OSZ-1:0]   base;
   logic             sq_unused;

   // m is Q1.(ISZ-1); its square is Q2.(2ISZ-2), top bit set means >= 2.0
   assign sq     = {{ISZ{1'b0}}, m} * {{ISZ{1'b0}}, m};
   assign sq_ge2 = sq[2*ISZ-1];
   assign f_sh   = {f[FW-2:0], sq_ge2};
   assign cnt_p1 = cnt + 5'd1;
   assign base   = {cnt_p1, {FSZ{1'b0}}};

   // low product bits and the shifted-out f MSB are never needed
   assign sq_unused = ^{sq[ISZ-2:0], f[FW-1]};

`ifdef LIN2LOG_ROUND_EN
   logic [FSZ+1:0] f_rnd;
   assign f_rnd = {1'b0, f_sh} + (FSZ+2)'(1);
   assign f_fin = f_rnd[FSZ+1:1];
`else
   assign f_fin = {1'b0, f_sh};
`endif

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.atten     = atten;
   assign bus.zero      = zero;

   // state and datapath registers, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         m     <= '0;
         cnt   <= '0;
         f     <= '0;
         idx   <= '0;
         atten <= '0;
         zero  <= 1'b0;
      end else begin
         state <= state_n;
         m     <= m_n;
         cnt   <= cnt_n;
         f     <= f_n;
         idx   <= idx_n;
         atten <= atten_n;
         zero  <= zero_n;
      end
   end

   // next-state and next-datapath decode
   always_comb begin
      state_n = state;
      m_n     = m;
      cnt_n   = cnt;
      f_n     = f;
      idx_n   = idx;
      atten_n = atten;
      zero_n  = zero;
      unique case (state)
         IDLE: begin
            if (bus.in_valid) begin
               m_n   = bus.lin;
               cnt_n = '0;
               f_n   = '0;
               if (bus.lin == '0) begin
                  zero_n  = 1'b1;
                  atten_n = '1;
                  state_n = DONE;
               end else begin
                  state_n = NORM;
               end
            end
         end
         NORM: begin
            if (!m[ISZ-1]) begin
               m_n   = {m[ISZ-2:0], 1'b0};
               cnt_n = cnt + 5'd1;
            end else begin
               idx_n   = IW'(FW - 1);
               state_n = FRAC;
            end
         end
         FRAC: begin
            f_n   = f_sh;
            m_n   = sq_ge2 ? sq[2*ISZ-1 -: ISZ]
                           : sq[2*ISZ-2 -: ISZ];
            idx_n = idx - IW'(1);
            if (idx == '0) begin
               atten_n = base - {{(OSZ-FSZ-1){1'b0}}, f_fin};
               zero_n  = 1'b0;
               state_n = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_lin2log.sv
// Directed bench for lin2log: hand-computed attenuation and latency.
// Expectations follow LIN2LOG_ROUND_EN when it is defined.
module tb_lin2log;
   localparam int ISZ = 16;
   localparam int FSZ = 8;
`ifdef LIN2LOG_ROUND_EN
   localparam int R = 1;
   localparam logic [31:0] FFFF_EXP = 32'h000;
`else
   localparam int R = 0;
   localparam logic [31:0] FFFF_EXP = 32'h001;
`endif

   logic clk;
   logic reset;
   int   evals;
   int   fails;

   lin2log_if #(.ISZ(ISZ), .FSZ(FSZ)) bus ();

   lin2log #(.ISZ(ISZ), .FSZ(FSZ)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      evals++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(inout int lat);
      while (!bus.out_valid && lat < 200) begin
         step();
         lat++;
      end
   endtask

   task automatic convert(input string tag,
                          input logic [15:0] lin,
                          input logic [31:0] exp_att,
                          input logic exp_zero,
                          input int exp_lat);
      int lat;
      int w;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         step();
         w++;
      end
      check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.lin      = lin;
      step();
      bus.in_valid = 1'b0;
      lat = 1;
      wait_out(lat);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_att"}, 32'(bus.atten), exp_att);
      check({tag, "_zero"}, 32'(bus.zero), 32'(exp_zero));
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
      check({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
   endtask

   // directed sequence
   initial begin
      int lat;
      evals         = 0;
      fails         = 0;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.lin       = '0;
      bus.out_ready = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      check("rst_rdy", 32'(bus.in_ready), 32'd1);
      check("rst_ov", 32'(bus.out_valid), 32'd0);
      check("rst_att", 32'(bus.atten), 32'd0);
      check("rst_zero", 32'(bus.zero), 32'd0);

      convert("l8000", 16'h8000, 32'h100, 1'b0, 10 + R);
      convert("l4000", 16'h4000, 32'h200, 1'b0, 11 + R);
      convert("l0001", 16'h0001, 32'h1000, 1'b0, 25 + R);
      convert("l0100", 16'h0100, 32'h800, 1'b0, 17 + R);
      convert("lb505", 16'hB505, 32'h080, 1'b0, 10 + R);
      convert("lffff", 16'hFFFF, FFFF_EXP, 1'b0, 10 + R);
      convert("l0000", 16'h0000, 32'h1FFF, 1'b1, 1);
      convert("l8000b", 16'h8000, 32'h100, 1'b0, 10 + R);

      // back-pressure: result held, second sample waits
      bus.in_valid = 1'b1;
      bus.lin      = 16'h4000;
      step();
      bus.lin = 16'h8000;
      lat = 1;
      wait_out(lat);
      check("bp_lat", 32'(lat), 32'(11 + R));
      for (int i = 0; i < 20; i++) begin
         step();
         check("bp_att", 32'(bus.atten), 32'h200);
         check("bp_rdy", 32'(bus.in_ready), 32'd0);
         check("bp_ov", 32'(bus.out_valid), 32'd1);
      end
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      check("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
      check("bp_rel_ov", 32'(bus.out_valid), 32'd0);
      step();
      bus.in_valid = 1'b0;
      check("bp_acc", 32'(bus.in_ready), 32'd0);
      lat = 1;
      wait_out(lat);
      check("bp2_lat", 32'(lat), 32'(10 + R));
      check("bp2_att", 32'(bus.atten), 32'h100);
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;

      // reset in the middle of the fraction phase
      bus.in_valid = 1'b1;
      bus.lin      = 16'h1234;
      step();
      bus.in_valid = 1'b0;
      repeat (6) step();
      check("mid_busy", 32'(bus.in_ready), 32'd0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mr_rdy", 32'(bus.in_ready), 32'd1);
      check("mr_ov", 32'(bus.out_valid), 32'd0);
      check("mr_att", 32'(bus.atten), 32'd0);
      check("mr_zero", 32'(bus.zero), 32'd0);
      for (int i = 0; i < 20; i++) begin
         step();
         check("mr_quiet", 32'(bus.out_valid), 32'd0);
      end
      convert("after_rst", 16'h8000, 32'h100, 1'b0, 10 + R);

      $display("End of test - %0d assertions evaluated, %0d failures",
               evals, fails);
      $finish;
   end
endmodule
